shared_event_fifo: RTL and testbench



---
 rtl/larpix_fifo_pkg.sv | 21 ++
 rtl/fifo_ram.sv | 27 ++
 rtl/shared_event_fifo.sv | 101 ++++++++++
 tb/tb_shared_event_fifo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/larpix_fifo_pkg.sv
// Shared sizing helpers for the event FIFO: depth and the pointer/count widths,
// all derived from the address width.
package larpix_fifo_pkg;

    localparam int WIDTH_DEFAULT     = 64;
    localparam int FIFO_BITS_DEFAULT = 11;

    function automatic int fifo_depth(input int bits);
        return 1 << bits;
    endfunction

    function automatic int ptr_width(input int bits);
        return bits;
    endfunction

    // One extra bit so a completely full queue (DEPTH) is representable.
    function automatic int cnt_width(input int bits);
        return bits + 1;
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port synchronous RAM: one write port and one registered read port.
// Kept as a standalone block so a foundry SRAM macro can be dropped in.
module fifo_ram #(
    parameter int WORD_W = 63,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/shared_event_fifo.sv
// Event buffer between the event builder and the UART transmit path: in-order
// storage with occupancy flags, sticky overflow and a high-water diagnostic.
module shared_event_fifo
    import larpix_fifo_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEFAULT,
    parameter int FIFO_BITS = FIFO_BITS_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-2:0]     data_in,
    input  logic                 write_fifo_n,
    input  logic                 read_fifo_n,
    input  logic                 clear_stats,
    output logic [WIDTH-2:0]     data_out,
    output logic                 fifo_full,
    output logic                 fifo_half,
    output logic                 fifo_empty,
    output logic [FIFO_BITS:0]   fifo_counter,
    output logic                 fifo_overflow,
    output logic [FIFO_BITS:0]   high_water
);

    localparam int PTR_W = ptr_width(FIFO_BITS);
    localparam int CNT_W = cnt_width(FIFO_BITS);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(fifo_depth(FIFO_BITS));
    localparam logic [CNT_W-1:0] HALF_C  = CNT_W'(fifo_depth(FIFO_BITS) / 2);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             wr_en;
    logic             rd_en;
    logic             ovf_evt;
    logic             out_vld;
    logic [WIDTH-2:0] ram_q;

    // A read frees a slot in the same cycle, so a full FIFO can still accept a write.
    always_comb begin
        rd_en   = !read_fifo_n && !fifo_empty;
        wr_en   = !write_fifo_n && (!fifo_full || rd_en);
        ovf_evt = !write_fifo_n && fifo_full && !rd_en;
        unique case ({wr_en, rd_en})
            2'b10:   count_next = fifo_counter + 1'b1;
            2'b01:   count_next = fifo_counter - 1'b1;
            default: count_next = fifo_counter;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_counter  <= '0;
            fifo_empty    <= 1'b1;
            fifo_full     <= 1'b0;
            fifo_half     <= 1'b0;
            fifo_overflow <= 1'b0;
            high_water    <= '0;
            out_vld       <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr  <= rd_ptr + 1'b1;
                out_vld <= 1'b1;
            end
            fifo_counter <= count_next;
            fifo_empty   <= (count_next == '0);
            fifo_full    <= (count_next == DEPTH_C);
            fifo_half    <= (count_next >= HALF_C);
            // An overflow in the same cycle as a clear must still be reported.
            if (ovf_evt) begin
                fifo_overflow <= 1'b1;
            end else if (clear_stats) begin
                fifo_overflow <= 1'b0;
            end
            if (clear_stats || (count_next > high_water)) begin
                high_water <= count_next;
            end
        end
    end

    fifo_ram #(
        .WORD_W (WIDTH - 1),
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (data_in),
        .re    (rd_en),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    // The RAM output register has no reset; mask it until the first read after reset.
    assign data_out = out_vld ? ram_q : '0;

endmodule

// File: tb/tb_shared_event_fifo.sv
// Directed bench for shared_event_fifo at 16 entries.
module tb_shared_event_fifo;

    localparam int WIDTH     = 64;
    localparam int FIFO_BITS = 4;
    localparam int DEPTH     = 16;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [WIDTH-2:0]    data_in;
    logic                write_fifo_n;
    logic                read_fifo_n;
    logic                clear_stats;
    logic [WIDTH-2:0]    data_out;
    logic                fifo_full;
    logic                fifo_half;
    logic                fifo_empty;
    logic [FIFO_BITS:0]  fifo_counter;
    logic                fifo_overflow;
    logic [FIFO_BITS:0]  high_water;

    int n_checks = 0;
    int n_pass   = 0;

    shared_event_fifo #(
        .WIDTH     (WIDTH),
        .FIFO_BITS (FIFO_BITS)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .data_in       (data_in),
        .write_fifo_n  (write_fifo_n),
        .read_fifo_n   (read_fifo_n),
        .clear_stats   (clear_stats),
        .data_out      (data_out),
        .fifo_full     (fifo_full),
        .fifo_half     (fifo_half),
        .fifo_empty    (fifo_empty),
        .fifo_counter  (fifo_counter),
        .fifo_overflow (fifo_overflow),
        .high_water    (high_water)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [WIDTH-2:0] d);
        write_fifo_n = 1'b0;
        data_in      = d;
        step();
        write_fifo_n = 1'b1;
    endtask

    task automatic do_read();
        read_fifo_n = 1'b0;
        step();
        read_fifo_n = 1'b1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n      = 1'b1;
        data_in      = '0;
        write_fifo_n = 1'b1;
        read_fifo_n  = 1'b1;
        clear_stats  = 1'b0;
        do_reset();
        step();

        // Reset state
        check("rst_count", fifo_counter, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_half", fifo_half, 0);
        check("rst_ovf", fifo_overflow, 0);
        check("rst_hw", high_water, 0);
        check("rst_dout", data_out, 0);

        // Basic write 3 / read 3
        for (int i = 1; i <= 3; i++) begin
            do_write(63'(i));
            check("basic_wr_count", fifo_counter, 64'(i));
        end
        for (int i = 1; i <= 3; i++) begin
            do_read();
            check("basic_rd_data", data_out, 64'(i));
            check("basic_rd_count", fifo_counter, 64'(3 - i));
        end
        check("basic_empty", fifo_empty, 1);

        // Fill to DEPTH: half at 8, full at 16
        for (int i = 0; i < DEPTH; i++) begin
            do_write(63'(64'h100 + i));
            check("fill_half", fifo_half, (i + 1 >= 8) ? 1 : 0);
            check("fill_full", fifo_full, (i + 1 == DEPTH) ? 1 : 0);
        end
        do_write(63'h1FF);
        check("ovf_flag", fifo_overflow, 1);
        check("ovf_count", fifo_counter, DEPTH);

        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        check("clr_ovf", fifo_overflow, 0);
        check("clr_hw_full", high_water, DEPTH);

        // Full with simultaneous read and write
        for (int k = 0; k < 5; k++) begin
            write_fifo_n = 1'b0;
            read_fifo_n  = 1'b0;
            data_in      = 63'(64'h200 + k);
            step();
            check("full_rw_data", data_out, 64'h100 + k);
            check("full_rw_count", fifo_counter, DEPTH);
            check("full_rw_ovf", fifo_overflow, 0);
        end
        write_fifo_n = 1'b1;
        read_fifo_n  = 1'b1;

        // Drain: remaining originals then the words written while full
        for (int i = 5; i < DEPTH; i++) begin
            do_read();
            check("drain_old", data_out, 64'h100 + i);
        end
        for (int k = 0; k < 5; k++) begin
            do_read();
            check("drain_new", data_out, 64'h200 + k);
        end
        check("drain_empty", fifo_empty, 1);

        // Empty with simultaneous read and write: no bypass
        write_fifo_n = 1'b0;
        read_fifo_n  = 1'b0;
        data_in      = 63'h300;
        step();
        write_fifo_n = 1'b1;
        read_fifo_n  = 1'b1;
        check("empty_rw_dout", data_out, 64'h204);
        check("empty_rw_count", fifo_counter, 1);
        check("empty_rw_empty", fifo_empty, 0);
        do_read();
        check("empty_rw_data", data_out, 64'h300);

        // High-water: fill to 10, drain to 2, clear
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        check("hw_cleared", high_water, 0);
        for (int i = 0; i < 10; i++) do_write(63'(64'h400 + i));
        for (int i = 0; i < 8; i++) begin
            do_read();
            check("hw_drain", data_out, 64'h400 + i);
        end
        check("hw_before", high_water, 10);
        clear_stats = 1'b1;
        step();
        clear_stats = 1'b0;
        check("hw_after", high_water, 2);
        check("hw_ovf", fifo_overflow, 0);

        // Reset with 5 entries queued
        for (int i = 0; i < 3; i++) do_write(63'(64'h500 + i));
        check("pre_rst_count", fifo_counter, 5);
        do_reset();
        check("mid_rst_count", fifo_counter, 0);
        check("mid_rst_empty", fifo_empty, 1);
        check("mid_rst_dout", data_out, 0);
        do_write(63'h555);
        do_read();
        check("post_rst_data", data_out, 64'h555);
        check("post_rst_empty", fifo_empty, 1);

        // Wrap-around: three full rounds, with overflow and clear in the same cycle
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < DEPTH; i++) do_write(63'(64'h1000 * (r + 1) + i));
            if (r == 1) begin
                write_fifo_n = 1'b0;
                clear_stats  = 1'b1;
                data_in      = 63'h7777;
                step();
                write_fifo_n = 1'b1;
                clear_stats  = 1'b0;
                check("ovf_beats_clear", fifo_overflow, 1);
                check("ovf_clr_count", fifo_counter, DEPTH);
            end
            for (int i = 0; i < DEPTH; i++) begin
                do_read();
                check("wrap_data", data_out, 64'h1000 * (r + 1) + i);
            end
            check("wrap_empty", fifo_empty, 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
